unidad_de_busqueda: RTL

UNIDAD_DE_BUSQUEDA -- requirements
Module: unidad_de_busqueda

---
 rtl/unidad_de_busqueda.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/unidad_de_busqueda.sv
// ============================================================================
// unidad_de_busqueda : instruction fetch unit (PC, IR, memory handshake, timeout)
// Revision: 1.0
// ============================================================================
`default_nettype none

module unidad_de_busqueda #(
  parameter int TIEMPO_ESPERA = 15
) (
  input  logic        Reloj,
  input  logic        Reiniciar,
  input  logic        LoadIR,
  input  logic        LoadPC,
  input  logic [1:0]  SelectPC,
  input  logic [15:0] Destino,
  input  logic [15:0] MemDato,
  input  logic        MemListo,
  output logic        MemLeer,
  output logic [15:0] MemDir,
  output logic [15:0] Instruccion,
  output logic [15:0] PC,
  output logic        InstruccionValida,
  output logic        Ocupado,
  output logic        ErrorBus
);

  typedef enum logic [0:0] {
    INACTIVO = 1'b0,
    ESPERA   = 1'b1
  } estado_t;

  localparam logic [15:0] c_nop    = 16'hC000;
  localparam logic [3:0]  c_limite = 4'(TIEMPO_ESPERA - 1);
  localparam logic [1:0]  c_sel_inc = 2'b00;
  localparam logic [1:0]  c_sel_abs = 2'b01;
  localparam logic [1:0]  c_sel_rel = 2'b10;

  // Registered state
  estado_t     r_estado;
  logic [15:0] r_pc;
  logic [15:0] r_mem_dir;
  logic [15:0] r_instr;
  logic        r_mem_leer;
  logic        r_valida;
  logic        r_error;
  logic [3:0]  r_cnt;
  logic        r_pend_valido;
  logic [1:0]  r_pend_sel;
  logic [15:0] r_pend_destino;

  // Next-state values
  estado_t     w_estado;
  logic [15:0] w_pc;
  logic [15:0] w_mem_dir;
  logic [15:0] w_instr;
  logic        w_mem_leer;
  logic        w_valida;
  logic        w_error;
  logic [3:0]  w_cnt;
  logic        w_pend_valido;
  logic [1:0]  w_pend_sel;
  logic [15:0] w_pend_destino;

  // Pending update as seen at this edge, including a LoadPC arriving now
  logic        w_pend_ef_valido;
  logic [1:0]  w_pend_ef_sel;
  logic [15:0] w_pend_ef_destino;
  logic        w_fin;

  function automatic logic [15:0] f_nuevo_pc(
    input logic [1:0]  sel,
    input logic [15:0] destino,
    input logic [15:0] instr,
    input logic [15:0] pc
  );
    logic [15:0] w_res;
    case (sel)
      c_sel_inc: w_res = pc + 16'd1;
      c_sel_abs: w_res = destino;
      c_sel_rel: w_res = pc + {{7{instr[8]}}, instr[8:0]};
      default:   w_res = pc;
    endcase
    return w_res;
  endfunction

  // A hold request (11) cancels whatever jump was queued during the fetch
  always_comb begin
    w_pend_ef_valido  = r_pend_valido;
    w_pend_ef_sel     = r_pend_sel;
    w_pend_ef_destino = r_pend_destino;
    if (LoadPC) begin
      w_pend_ef_valido  = (SelectPC != 2'b11);
      w_pend_ef_sel     = SelectPC;
      w_pend_ef_destino = Destino;
    end
  end

  assign w_fin = MemListo || (r_cnt == c_limite);

  always_comb begin
    w_estado       = r_estado;
    w_pc           = r_pc;
    w_mem_dir      = r_mem_dir;
    w_instr        = r_instr;
    w_mem_leer     = r_mem_leer;
    w_valida       = 1'b0;
    w_error        = r_error;
    w_cnt          = r_cnt;
    w_pend_valido  = r_pend_valido;
    w_pend_sel     = r_pend_sel;
    w_pend_destino = r_pend_destino;

    case (r_estado)
      INACTIVO: begin
        if (LoadPC) begin
          w_pc = f_nuevo_pc(SelectPC, Destino, r_instr, r_pc);
        end
        if (LoadIR) begin
          w_estado      = ESPERA;
          w_mem_leer    = 1'b1;
          w_mem_dir     = r_pc;
          w_cnt         = 4'd0;
          w_pend_valido = 1'b0;
        end
      end

      ESPERA: begin
        w_pend_valido  = w_pend_ef_valido;
        w_pend_sel     = w_pend_ef_sel;
        w_pend_destino = w_pend_ef_destino;
        if (w_fin) begin
          // Relative target uses the instruction that was current before this edge
          if (w_pend_ef_valido) begin
            w_pc = f_nuevo_pc(w_pend_ef_sel, w_pend_ef_destino, r_instr, r_pc);
          end
          w_instr       = MemListo ? MemDato : c_nop;
          w_error       = r_error | ~MemListo;
          w_valida      = 1'b1;
          w_mem_leer    = 1'b0;
          w_estado      = INACTIVO;
          w_pend_valido = 1'b0;
        end else begin
          w_cnt = r_cnt + 4'd1;
        end
      end

      default: begin
        w_estado = INACTIVO;
      end
    endcase
  end

  always_ff @(posedge Reloj or negedge Reiniciar) begin
    if (!Reiniciar) begin
      r_estado       <= INACTIVO;
      r_pc           <= 16'h0000;
      r_mem_dir      <= 16'h0000;
      r_instr        <= c_nop;
      r_mem_leer     <= 1'b0;
      r_valida       <= 1'b0;
      r_error        <= 1'b0;
      r_cnt          <= 4'd0;
      r_pend_valido  <= 1'b0;
      r_pend_sel     <= 2'b00;
      r_pend_destino <= 16'h0000;
    end else begin
      r_estado       <= w_estado;
      r_pc           <= w_pc;
      r_mem_dir      <= w_mem_dir;
      r_instr        <= w_instr;
      r_mem_leer     <= w_mem_leer;
      r_valida       <= w_valida;
      r_error        <= w_error;
      r_cnt          <= w_cnt;
      r_pend_valido  <= w_pend_valido;
      r_pend_sel     <= w_pend_sel;
      r_pend_destino <= w_pend_destino;
    end
  end

  assign MemLeer           = r_mem_leer;
  assign MemDir            = r_mem_dir;
  assign Instruccion       = r_instr;
  assign PC                = r_pc;
  assign InstruccionValida = r_valida;
  assign Ocupado           = (r_estado == ESPERA);
  assign ErrorBus          = r_error;

endmodule

`default_nettype wire
